input_debouncer: RTL
====================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent input channels; SHALL be >= 1.
REQ-002 Parameter PRESCALE, default 8192: clock cycles per sample tick; SHALL be >= 1.
REQ-003 Parameter SAMPLES, default 4: consecutive equal samples needed to change level; SHALL be >= 2.
REQ-004 Parameter ACTIVE_LOW, default 1: when 1, raw inputs are inverted before sampling, so a pressed button reads as 1.
REQ-005 Port clock, input, 1: the single clock of the block.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port raw, input, CHANNELS: asynchronous pin inputs.
REQ-008 Port rise_en, input, CHANNELS: per-channel enable for rising-edge capture into pending.
REQ-009 Port fall_en, input, CHANNELS: per-channel enable for falling-edge capture into pending.
REQ-010 Port clear, input, CHANNELS: per-channel pending clear, level-sensitive.
REQ-011 Port level, output, CHANNELS: debounced, polarity-corrected state.
REQ-012 Port rise, output, CHANNELS: one-cycle pulse when level goes 0->1.
REQ-013 Port fall, output, CHANNELS: one-cycle pulse when level goes 1->0.
REQ-014 Port pending, output, CHANNELS: sticky edge-event flags.
REQ-015 Port irq, output, 1: OR of all pending bits.

Function
REQ-016 Each raw bit SHALL pass a 2-flop synchronizer, then the ACTIVE_LOW inversion.
REQ-017 The shared prescaler SHALL count 0..PRESCALE-1, wrap to 0, and assert tick in the cycle its count equals PRESCALE-1. With PRESCALE=1, tick SHALL be asserted every cycle.
REQ-018 On each tick, each channel SHALL shift its synchronized sample into a SAMPLES-deep history; without a tick, the history SHALL hold.
REQ-019 Level SHALL become 1 when the history is all ones, 0 when it is all zeros, and otherwise hold. The update SHALL appear in the cycle after the qualifying tick.
REQ-020 Rise and fall SHALL be registered and asserted in the same cycle level first shows its new value, for exactly one cycle.
REQ-021 Pending[i] SHALL set in the cycle after (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]), and clear in the cycle after clear[i]. If set and clear coincide, set SHALL win.
REQ-022 Irq SHALL equal the combinational OR of the registered pending bits, with no extra latency.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be reported in the same cycle.
REQ-024 A steady input SHALL change level no sooner than (SAMPLES-1)*PRESCALE+3 and no later than SAMPLES*PRESCALE+3 cycles after the raw change.

Reset
REQ-025 While reset is high, the synchronizers, prescaler, histories, level, rise, fall, pending and irq SHALL all be 0 at the next clock edge.
REQ-026 Reset mid-debounce SHALL discard partial history. An input already active at reset release SHALL produce a rise pulse after SAMPLES fresh ticks.

Structure
REQ-027 No shared-package types SHALL be required; the prescaler width SHALL be $clog2(PRESCALE) computed locally, with a 1-bit minimum.
REQ-028 The block SHALL contain one sub-module, debounce_channel (synchronizer, history, level, rise/fall, pending), generated CHANNELS times. The prescaler SHALL live in the parent.
REQ-029 The parent SHALL reject illegal parameter values at elaboration.

Verification
All scenarios use CHANNELS=3, PRESCALE=4, SAMPLES=4, ACTIVE_LOW=1.
REQ-030 Clean press: raw[0] 1->0 and held -> level[0]=1 between cycle 15 and 19, rise[0] high exactly 1 cycle, channels 1-2 unchanged.
REQ-031 Bounce: toggle raw[0] every 5 cycles for 40 cycles, then hold 0 -> exactly one rise[0] pulse and no fall[0] pulse.
REQ-032 Pending: rise_en=3'b001; press ch0 -> pending=3'b001 and irq=1; then assert clear[0] in the same cycle as a new enabled edge -> pending[0] stays 1; clear alone -> pending=0, irq=0.
REQ-033 Masked edge: fall_en=0; release ch0 -> fall[0] pulses, pending[0] stays 0, irq stays 0.
REQ-034 Reset mid-operation: raw[1]=0 held; assert reset after 2 ticks -> all outputs 0 next cycle; after release, rise[1] only after 4 fresh ticks.
REQ-035 Simultaneous: press ch0 and ch2 in the same cycle with rise_en=3'b111 -> rise=3'b101 in one cycle, pending=3'b101 in the next.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// ============================================================================
// input_debouncer_pkg
// Default parameter values and legal minimums shared by the debouncer
// top level and its per-channel sub-module. Contains no types; nothing
// outside this block depends on it.
// ============================================================================
package input_debouncer_pkg;

    localparam int unsigned DEFAULT_CHANNELS   = 3;
    localparam int unsigned DEFAULT_PRESCALE   = 8192;
    localparam int unsigned DEFAULT_SAMPLES    = 4;
    localparam bit          DEFAULT_ACTIVE_LOW = 1'b1;

    localparam int unsigned MIN_CHANNELS = 1;
    localparam int unsigned MIN_PRESCALE = 1;
    localparam int unsigned MIN_SAMPLES  = 2;

endpackage

// File: rtl/input_debouncer_channel.sv
// ============================================================================
// debounce_channel
// One debounced input: 2-flop synchronizer, optional inversion, sample
// history shifted on the shared tick, hysteretic level, registered edge
// pulses and a sticky pending flag.
//
// Ports
//   clock    : block clock
//   reset    : synchronous active-high reset
//   tick     : shared sample strobe from the parent prescaler
//   raw      : asynchronous pin input
//   rise_en  : allow a rising edge to set pending
//   fall_en  : allow a falling edge to set pending
//   clear    : level-sensitive pending clear (loses to a simultaneous set)
//   level    : debounced, polarity-corrected state
//   rise     : one-cycle pulse, coincident with level first reading 1
//   fall     : one-cycle pulse, coincident with level first reading 0
//   pending  : sticky edge-event flag
// ============================================================================
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int unsigned SAMPLES    = DEFAULT_SAMPLES,
    parameter bit          ACTIVE_LOW = DEFAULT_ACTIVE_LOW
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    input  logic rise_en,
    input  logic fall_en,
    input  logic clear,
    output logic level,
    output logic rise,
    output logic fall,
    output logic pending
);

    logic               sync0;
    logic               sync1;
    logic               sample;
    logic [SAMPLES-1:0] hist;
    logic [SAMPLES-1:0] hist_next;
    logic               level_next;

    // Inversion sits after the synchronizer so the flops see the pin as-is.
    assign sample = sync1 ^ ACTIVE_LOW;

    // Level is decided from the history as it will be after this tick, so
    // the new level appears in the cycle right after the qualifying tick
    // rather than one cycle later.
    // NOTE: every always_comb output gets a default first; otherwise a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        hist_next  = {hist[SAMPLES-2:0], sample};
        level_next = level;
        if (tick) begin
            if (&hist_next) begin
                level_next = 1'b1;
            end else if (~|hist_next) begin
                level_next = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // The history is a small shift register, not a memory, so it is
            // cleared: a reset mid-debounce must discard partial evidence.
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            hist    <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            if (tick) begin
                hist <= hist_next;
            end
            level   <= level_next;
            rise    <= level_next & ~level;
            fall    <= ~level_next & level;
            // Set terms are ORed after the clear mask so a coincident set wins.
            pending <= (pending & ~clear) | (rise & rise_en) | (fall & fall_en);
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// ============================================================================
// input_debouncer
// CHANNELS independent push-button debouncers sharing one sample prescaler.
// Each channel needs SAMPLES consecutive equal samples, taken every
// PRESCALE clocks, before its level changes.
//
// Ports
//   clock    : block clock
//   reset    : synchronous active-high reset
//   raw      : [CHANNELS] asynchronous pin inputs
//   rise_en  : [CHANNELS] rising-edge capture enables for pending
//   fall_en  : [CHANNELS] falling-edge capture enables for pending
//   clear    : [CHANNELS] level-sensitive pending clears
//   level    : [CHANNELS] debounced levels (1 = pressed when ACTIVE_LOW)
//   rise     : [CHANNELS] one-cycle 0->1 pulses
//   fall     : [CHANNELS] one-cycle 1->0 pulses
//   pending  : [CHANNELS] sticky edge-event flags
//   irq      : OR of all pending bits
// ============================================================================
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned CHANNELS   = DEFAULT_CHANNELS,
    parameter int unsigned PRESCALE   = DEFAULT_PRESCALE,
    parameter int unsigned SAMPLES    = DEFAULT_SAMPLES,
    parameter bit          ACTIVE_LOW = DEFAULT_ACTIVE_LOW
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw,
    input  logic [CHANNELS-1:0] rise_en,
    input  logic [CHANNELS-1:0] fall_en,
    input  logic [CHANNELS-1:0] clear,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] pending,
    output logic                irq
);

    // Elaboration-time parameter guards.
    if (CHANNELS < MIN_CHANNELS) begin : g_bad_channels
        $error("input_debouncer: CHANNELS must be >= 1");
    end
    if (PRESCALE < MIN_PRESCALE) begin : g_bad_prescale
        $error("input_debouncer: PRESCALE must be >= 1");
    end
    if (SAMPLES < MIN_SAMPLES) begin : g_bad_samples
        $error("input_debouncer: SAMPLES must be >= 2");
    end

    // A 1-bit counter is kept for PRESCALE=1; it never leaves 0, so tick is
    // asserted every cycle.
    localparam int unsigned PRESCALE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] count;
    logic                  tick;

    assign tick = (count == PRESCALE_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SAMPLES    (SAMPLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .tick    (tick),
            .raw     (raw[i]),
            .rise_en (rise_en[i]),
            .fall_en (fall_en[i]),
            .clear   (clear[i]),
            .level   (level[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .pending (pending[i])
        );
    end

    assign irq = |pending;

endmodule
